// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier covering MUL, MULH, MULHSU and MULHU.
// Define MUL_EARLY_EXIT_EN to leave CALC once the remaining multiplier bits are all zero.
module seq_multiplier #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] opr1_i,
   input  logic [XLEN-1:0] opr2_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] res_o,
   output logic [1:0]      state_o
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;

   localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

   logic [1:0]        state_q,  state_d;
   logic [1:0]        op_q,     op_d;
   logic [2*XLEN-1:0] mcand_q,  mcand_d;
   logic [XLEN-1:0]   mplier_q, mplier_d;
   logic [2*XLEN-1:0] acc_q,    acc_d;
   logic              sign_q,   sign_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic              done_q,   done_d;
   logic [XLEN-1:0]   res_q,    res_d;

   logic              neg1, neg2;
   logic [XLEN-1:0]   mag1, mag2;
   logic [XLEN-1:0]   mplier_shr;
   logic [2*XLEN-1:0] prod;
   logic              calc_last;

   // Only the operands treated as signed by the selected op get their magnitude taken.
   assign neg1 = ((op_i == OP_MULH) || (op_i == OP_MULHSU)) && opr1_i[XLEN-1];
   assign neg2 = (op_i == OP_MULH) && opr2_i[XLEN-1];
   assign mag1 = neg1 ? (~opr1_i + 1'b1) : opr1_i;
   assign mag2 = neg2 ? (~opr2_i + 1'b1) : opr2_i;

   assign mplier_shr = mplier_q >> 1;
   assign prod       = sign_q ? (~acc_q + 1'b1) : acc_q;

`ifdef MUL_EARLY_EXIT_EN
   assign calc_last = (mplier_shr == '0) || (cnt_q == CNT_W'(XLEN - 1));
`else
   assign calc_last = (cnt_q == CNT_W'(XLEN - 1));
`endif

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      sign_d   = sign_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      res_d    = res_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               op_d     = op_i;
               mcand_d  = {{XLEN{1'b0}}, mag1};
               mplier_d = mag2;
               acc_d    = '0;
               sign_d   = neg1 ^ neg2;
               cnt_d    = '0;
               // A zero operand makes the product zero; go straight to FIX.
               state_d  = ((opr1_i == '0) || (opr2_i == '0)) ? FIX : CALC;
            end
         end
         CALC: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mplier_d = mplier_shr;
            mcand_d  = mcand_q << 1;
            cnt_d    = cnt_q + 1'b1;
            if (calc_last) state_d = FIX;
         end
         FIX: begin
            acc_d   = prod;
            res_d   = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         sign_q   <= 1'b0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         res_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         sign_q   <= sign_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         res_q    <= res_d;
      end
   end

   assign busy_o  = (state_q == CALC) || (state_q == FIX);
   assign done_o  = done_q;
   assign res_o   = res_q;
   assign state_o = state_q;

endmodule
